fifo_uart_tx: RTL and testbench

- Serial transmit stage that sits directly downstream of the 8-entry byte FIFO.
- Pops bytes from the FIFO's read side using its rd/empty/data_out interface and serialises each byte onto an 8N1 UART line, with optional parity.
- Drains the FIFO autonomously while enabled; one byte per frame, back-to-back when data is available.

---
 rtl/fifo_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : Serial transmit stage placed directly after an 8-entry byte
//             FIFO. While enabled it pops one byte at a time through the
//             FIFO read side (rd / empty / data_out) and serialises it as an
//             8N1 UART frame, with an optional even/odd parity bit inserted
//             between D7 and the stop bit. Frames run back-to-back whenever
//             the FIFO holds data.
//
//  Ports    : clk        in   system clock, rising-edge active
//             rst        in   asynchronous reset, active low (0 = in reset)
//             tx_en      in   allows a new frame to start (sampled in IDLE)
//             fifo_empty in   FIFO empty flag (sampled in IDLE)
//             fifo_data  in   FIFO data_out, valid the cycle after fifo_rd
//             fifo_rd    out  single-cycle FIFO read strobe
//             tx         out  serial line, idles high, register driven
//             busy       out  high whenever the state is not IDLE
//             byte_done  out  one-cycle pulse in the last cycle of the stop bit
//
//  Revision : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,  // clk cycles per serial bit, >= 2
    parameter int PARITY_EN    = 0,   // 1 inserts a parity bit before stop
    parameter int PARITY_ODD   = 0    // with parity: 0 = even, 1 = odd
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Last count of a bit time, and the count one before it (used to launch
    // byte_done so that the registered pulse lines up with the last cycle).
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_PRE  = c_BAUD_W'(CLKS_PER_BIT - 2);

    localparam logic [2:0] c_LAST_BIT = 3'd7;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [c_BAUD_W-1:0]   r_baud;       // cycle position within a bit time
    logic [2:0]            r_bit_idx;    // data bit being sent, 0..7
    logic [7:0]            r_shift;      // remaining data bits, LSB next
    logic                  r_parity;     // parity bit for the current byte
    logic                  r_tx;         // serial line register
    logic                  r_byte_done;  // end-of-frame pulse register

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  w_bit_end;    // last cycle of the current bit time
    logic [c_BAUD_W-1:0]   w_baud_next;  // baud counter value for next cycle
    logic                  w_parity;     // parity of the byte on fifo_data
    logic                  w_start_ok;   // IDLE may launch a fetch

    assign w_bit_end   = (r_baud == c_BAUD_LAST);
    assign w_baud_next = w_bit_end ? '0 : (r_baud + 1'b1);
    assign w_parity    = (PARITY_ODD != 0) ? ~(^fifo_data) : (^fifo_data);
    assign w_start_ok  = tx_en & ~fifo_empty;

    // ------------------------------------------------------------------------
    // Frame sequencer
    //
    // tx is always updated on the edge that enters a bit, so the line value
    // for every bit comes straight from r_tx. The shift register is advanced
    // as each bit is launched, leaving the next bit to send at r_shift[0].
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_start_ok) begin
                        r_state <= S_FETCH;
                    end
                end

                // fifo_rd is high for exactly this one cycle; the FIFO
                // presents the popped byte on the following cycle.
                S_FETCH: begin
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_shift   <= fifo_data;
                    r_parity  <= w_parity;
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= S_START;
                end

                S_START: begin
                    r_baud <= w_baud_next;
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    r_baud <= w_baud_next;
                    if (w_bit_end) begin
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                end

                S_PARITY: begin
                    r_baud <= w_baud_next;
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end

                S_STOP: begin
                    r_baud <= w_baud_next;
                    // Raised one cycle early so the registered pulse occupies
                    // the final stop-bit cycle.
                    if (r_baud == c_BAUD_PRE) begin
                        r_byte_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. fifo_rd and busy are pure decodes of the state register, so
    // they drop in the same instant as an asynchronous reset.
    // ------------------------------------------------------------------------
    assign fifo_rd   = (r_state == S_FETCH);
    assign busy      = (r_state != S_IDLE);
    assign tx        = r_tx;
    assign byte_done = r_byte_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Purpose  : Self-checking bench for fifo_uart_tx. Three instances share
//             clock, reset and tx_en: #0 without parity, #1 even parity,
//             #2 odd parity, each fed by its own 8-entry FIFO model. Expected
//             frames (hand-written bit vectors) are queued by the stimulus; a
//             separate monitor pops and compares them as frames appear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_CLKS = 4;
    localparam int c_NDUT = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic tx_en = 1'b0;

    logic [2:0] push_v = '0;
    logic [7:0] push_data [c_NDUT];
    logic [2:0] empty_v;
    logic [2:0] rd_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] bd_v;
    logic [7:0] data_v [c_NDUT] = '{8'h00, 8'h00, 8'h00};

    // FIFO models
    logic [7:0] fmem [c_NDUT][8];
    logic [2:0] wptr [c_NDUT] = '{3'd0, 3'd0, 3'd0};
    logic [2:0] rptr [c_NDUT] = '{3'd0, 3'd0, 3'd0};
    int         fcount [c_NDUT] = '{0, 0, 0};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          dut;
        logic [10:0] frame;   // bit i is the i-th bit on the line
        int          nbits;
        bit          b2b;     // follows the previous frame back-to-back
        bit          abort;   // frame is cut short by reset
    } exp_t;

    exp_t exp_q[$];

    // Monitor state
    bit          mon_act [c_NDUT] = '{0, 0, 0};
    int          mon_idx [c_NDUT];
    int          mon_gap [c_NDUT] = '{1000, 1000, 1000};
    int          mon_bad [c_NDUT];
    logic [10:0] mon_rx  [c_NDUT];
    exp_t        mon_it  [c_NDUT];
    int          rd_cnt  [c_NDUT] = '{0, 0, 0};
    int          viol    [c_NDUT] = '{0, 0, 0};

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < c_NDUT; g++) begin : g_dut
            fifo_uart_tx #(
                .CLKS_PER_BIT (c_CLKS),
                .PARITY_EN    ((g > 0) ? 1 : 0),
                .PARITY_ODD   ((g == 2) ? 1 : 0)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .tx_en      (tx_en),
                .fifo_empty (empty_v[g]),
                .fifo_data  (data_v[g]),
                .fifo_rd    (rd_v[g]),
                .tx         (tx_v[g]),
                .busy       (busy_v[g]),
                .byte_done  (bd_v[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FIFO models: data_out updates on the edge that sees rd.
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        for (int d = 0; d < c_NDUT; d++) begin
            if (push_v[d]) begin
                fmem[d][wptr[d]] <= push_data[d];
                wptr[d]          <= wptr[d] + 3'd1;
            end
            if (rd_v[d]) begin
                data_v[d] <= fmem[d][rptr[d]];
                rptr[d]   <= rptr[d] + 3'd1;
            end
            fcount[d] <= fcount[d] + (push_v[d] ? 1 : 0) - (rd_v[d] ? 1 : 0);
        end
    end

    always_comb begin
        empty_v = '0;
        for (int d = 0; d < c_NDUT; d++) begin
            empty_v[d] = (fcount[d] == 0);
        end
    end

    // ------------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t",
                     name, d, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples every DUT on the falling edge.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        int k;
        int bit_i;
        for (int d = 0; d < c_NDUT; d++) begin
            if (!rst) begin
                if (mon_act[d]) begin
                    check("abort_expected", d, 32'(mon_it[d].abort), 32'd1);
                    mon_act[d] = 1'b0;
                end
                mon_gap[d] = 0;
            end else begin
                if (rd_v[d]) begin
                    rd_cnt[d]++;
                    if (empty_v[d]) viol[d]++;
                end
                if (!mon_act[d]) begin
                    if (bd_v[d]) viol[d]++;
                    if (!tx_v[d]) begin
                        k = -1;
                        for (int i = 0; i < exp_q.size(); i++) begin
                            if (k < 0 && exp_q[i].dut == d) k = i;
                        end
                        n_checks++;
                        if (k < 0) begin
                            n_errors++;
                            $display("FAIL unexpected_frame dut%0d: got start bit expected none at %0t",
                                     d, $time);
                        end else begin
                            mon_it[d] = exp_q[k];
                            exp_q.delete(k);
                            if (mon_it[d].b2b) begin
                                check("b2b_gap", d, 32'(mon_gap[d]), 32'd3);
                            end
                            mon_act[d] = 1'b1;
                            mon_idx[d] = 0;
                            mon_bad[d] = 0;
                            mon_rx[d]  = '0;
                        end
                    end else begin
                        mon_gap[d]++;
                    end
                end
                if (mon_act[d]) begin
                    bit_i = mon_idx[d] / c_CLKS;
                    if (tx_v[d] !== mon_it[d].frame[bit_i]) mon_bad[d]++;
                    if (bd_v[d] !== (mon_idx[d] == mon_it[d].nbits * c_CLKS - 1)) mon_bad[d]++;
                    if (mon_idx[d] % c_CLKS == c_CLKS / 2) mon_rx[d][bit_i] = tx_v[d];
                    mon_idx[d]++;
                    if (mon_idx[d] == mon_it[d].nbits * c_CLKS) begin
                        check("frame_bits", d, 32'(mon_rx[d]), 32'(mon_it[d].frame));
                        check("frame_timing", d, 32'(mon_bad[d]), 32'd0);
                        check("abort_missing", d, 32'(mon_it[d].abort), 32'd0);
                        mon_act[d] = 1'b0;
                        mon_gap[d] = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic push_byte(input int d, input logic [7:0] b);
        push_data[d] = b;
        push_v[d]    = 1'b1;
        @(negedge clk);
        push_v[d]    = 1'b0;
    endtask

    task automatic expect_frame(input int d, input logic [10:0] f, input int nb,
                                input bit b2b, input bit ab);
        exp_t e;
        e.dut   = d;
        e.frame = f;
        e.nbits = nb;
        e.b2b   = b2b;
        e.abort = ab;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_v != 3'b000 ||
                mon_act[0] || mon_act[1] || mon_act[2]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 0, 32'(n >= budget), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int rd0;
        int rd1;
        int rd2;
        int bad;

        push_data = '{8'h00, 8'h00, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 0, 32'(tx_v), 32'h7);
        check("rst_busy", 0, 32'(busy_v), 32'h0);
        check("rst_fifo_rd", 0, 32'(rd_v), 32'h0);
        check("rst_byte_done", 0, 32'(bd_v), 32'h0);
        rst   = 1'b1;
        tx_en = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte 0xA5, no parity
        rd0 = rd_cnt[0];
        expect_frame(0, 11'b0_1_10100101_0, 10, 1'b0, 1'b0);
        push_byte(0, 8'hA5);
        wait_idle(200, "t1_timeout");
        check("t1_rd_pulses", 0, 32'(rd_cnt[0] - rd0), 32'd1);
        check("t1_fifo_count", 0, 32'(fcount[0]), 32'd0);

        // 2: back-to-back 0x00, 0xFF, 0x3C
        rd0 = rd_cnt[0];
        expect_frame(0, 11'b0_1_00000000_0, 10, 1'b0, 1'b0);
        expect_frame(0, 11'b0_1_11111111_0, 10, 1'b1, 1'b0);
        expect_frame(0, 11'b0_1_00111100_0, 10, 1'b1, 1'b0);
        push_byte(0, 8'h00);
        push_byte(0, 8'hFF);
        push_byte(0, 8'h3C);
        wait_idle(600, "t2_timeout");
        check("t2_rd_pulses", 0, 32'(rd_cnt[0] - rd0), 32'd3);
        check("t2_busy", 0, 32'(busy_v[0]), 32'd0);
        check("t2_tx_idle", 0, 32'(tx_v[0]), 32'd1);

        // 3: parity frames, even on #1, odd on #2
        rd1 = rd_cnt[1];
        rd2 = rd_cnt[2];
        expect_frame(1, 11'b1_0_10100101_0, 11, 1'b0, 1'b0);
        expect_frame(2, 11'b1_0_00000111_0, 11, 1'b0, 1'b0);
        expect_frame(1, 11'b1_1_00000111_0, 11, 1'b1, 1'b0);
        push_byte(1, 8'hA5);
        push_byte(2, 8'h07);
        push_byte(1, 8'h07);
        wait_idle(600, "t3_timeout");
        check("t3_rd_pulses_even", 1, 32'(rd_cnt[1] - rd1), 32'd2);
        check("t3_rd_pulses_odd", 2, 32'(rd_cnt[2] - rd2), 32'd1);

        // 4: empty FIFO with tx_en=1, then a byte present with tx_en=0
        rd0 = rd_cnt[0];
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_v != 3'b000 || tx_v != 3'b111 || busy_v != 3'b000) bad++;
        end
        check("t4_empty_activity", 0, 32'(bad), 32'd0);
        tx_en = 1'b0;
        push_byte(0, 8'h5A);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (rd_v[0] || busy_v[0] || !tx_v[0]) bad++;
        end
        check("t4_disabled_activity", 0, 32'(bad), 32'd0);
        check("t4_fifo_count", 0, 32'(fcount[0]), 32'd1);
        check("t4_rd_pulses", 0, 32'(rd_cnt[0] - rd0), 32'd0);
        expect_frame(0, 11'b0_1_01011010_0, 10, 1'b0, 1'b0);
        tx_en = 1'b1;
        wait_idle(200, "t4_timeout");
        check("t4_fifo_drained", 0, 32'(fcount[0]), 32'd0);

        // 5: tx_en dropped during DATA with two bytes queued
        rd0 = rd_cnt[0];
        expect_frame(0, 11'b0_1_10000001_0, 10, 1'b0, 1'b0);
        push_byte(0, 8'h81);
        push_byte(0, 8'h42);
        repeat (10) @(negedge clk);
        check("t5_busy_mid_frame", 0, 32'(busy_v[0]), 32'd1);
        tx_en = 1'b0;
        repeat (60) @(negedge clk);
        wait_idle(200, "t5_timeout");
        check("t5_rd_pulses", 0, 32'(rd_cnt[0] - rd0), 32'd1);
        check("t5_fifo_count", 0, 32'(fcount[0]), 32'd1);
        expect_frame(0, 11'b0_1_01000010_0, 10, 1'b0, 1'b0);
        tx_en = 1'b1;
        wait_idle(200, "t5b_timeout");
        check("t5_fifo_drained", 0, 32'(fcount[0]), 32'd0);

        // 6: reset mid-DATA, then a clean frame
        rd0 = rd_cnt[0];
        expect_frame(0, 11'b0_1_11000011_0, 10, 1'b0, 1'b1);
        push_byte(0, 8'hC3);
        repeat (11) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_tx", 0, 32'(tx_v[0]), 32'd1);
        check("t6_rst_busy", 0, 32'(busy_v[0]), 32'd0);
        check("t6_rst_fifo_rd", 0, 32'(rd_v[0]), 32'd0);
        check("t6_rst_byte_done", 0, 32'(bd_v[0]), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("t6_fifo_count", 0, 32'(fcount[0]), 32'd0);
        expect_frame(0, 11'b0_1_00111100_0, 10, 1'b0, 1'b0);
        push_byte(0, 8'h3C);
        wait_idle(200, "t6_timeout");
        check("t6_rd_pulses", 0, 32'(rd_cnt[0] - rd0), 32'd2);

        // Global protocol checks
        for (int d = 0; d < c_NDUT; d++) begin
            check("rd_on_empty_or_stray_done", d, 32'(viol[d]), 32'd0);
        end
        check("pending_frames", 0, 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
